// File: rtl/muldiv_if.sv
// Handshake and result bus between the core and the RV32M multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic            reg_write;
   logic [4:0]      rd_out;
   logic [XLEN-1:0] result;

   // Core side: issues operations, observes completion.
   modport master (
      output start, funct3, rs1_data, rs2_data, rd_in,
      input  busy, done, reg_write, rd_out, result
   );

   // Unit side.
   modport slave (
      input  start, funct3, rs1_data, rs2_data, rd_in,
      output busy, done, reg_write, rd_out, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide sharing one 64-bit accumulator. Division by zero and
// signed overflow complete in a single cycle.
// Optional: define MULDIV_FAST_MUL_EN to compute all multiplies with one
// combinational 64-bit multiply at single-cycle latency.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   localparam int unsigned W  = XLEN;
   localparam int unsigned DW = 2 * XLEN;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [DW-1:0]   acc, acc_nx;      // hi: partial product / remainder, lo: multiplier / quotient
   logic [W-1:0]    opnd, opnd_nx;    // multiplicand magnitude or divisor magnitude
   logic [2:0]      fn, fn_nx;
   logic            neg, neg_nx;
   logic [W-1:0]    result_q, result_nx;
   logic [4:0]      rd_q, rd_nx;
   logic            busy_q, done_q;

   // Capture-time decode of the incoming request.
   logic            in_div, in_sgn_a, in_sgn_b, in_neg_a, in_neg_b;
   logic [W-1:0]    in_mag_a, in_mag_b;
   logic            in_div_zero, in_ovf;
   logic [W-1:0]    in_special;
   logic            in_neg_res;

   // One iteration of each algorithm.
   logic [W:0]      mul_sum;
   logic [DW-1:0]   mul_step;
   logic [W:0]      div_sh, div_diff;
   logic [DW-1:0]   div_step;
   logic [DW-1:0]   step_val;

   // Sign-correct the raw magnitude result and select the returned word.
   function automatic logic [W-1:0] pick_result(input logic [2:0] f, input logic n,
                                                input logic [DW-1:0] v);
      logic [DW-1:0] p;
      logic [W-1:0]  q, r;
      p = n ? (DW'(0) - v) : v;
      q = n ? (W'(0) - v[W-1:0]) : v[W-1:0];
      r = n ? (W'(0) - v[DW-1:W]) : v[DW-1:W];
      if (f[2])
         pick_result = f[1] ? r : q;
      else if (f[1:0] == 2'b00)
         pick_result = p[W-1:0];
      else
         pick_result = p[DW-1:W];
   endfunction

   // Operand signedness, magnitudes, result sign and single-cycle special cases.
   always_comb begin
      in_div      = bus.funct3[2];
      in_sgn_a    = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
      in_sgn_b    = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
      in_neg_a    = in_sgn_a & bus.rs1_data[W-1];
      in_neg_b    = in_sgn_b & bus.rs2_data[W-1];
      in_mag_a    = in_neg_a ? (W'(0) - bus.rs1_data) : bus.rs1_data;
      in_mag_b    = in_neg_b ? (W'(0) - bus.rs2_data) : bus.rs2_data;
      in_neg_res  = (in_div & bus.funct3[1]) ? in_neg_a : (in_neg_a ^ in_neg_b);
      in_div_zero = in_div & (bus.rs2_data == '0);
      in_ovf      = in_div & ~bus.funct3[0]
                    & (bus.rs1_data == {1'b1, {(W-1){1'b0}}})
                    & (bus.rs2_data == '1);
      if (in_div_zero)
         in_special = bus.funct3[1] ? bus.rs1_data : '1;
      else
         in_special = bus.funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [DW-1:0] fast_a, fast_b, fast_prod;

   // Full-width signed/unsigned product in one cycle.
   always_comb begin
      fast_a    = {{W{in_sgn_a & bus.rs1_data[W-1]}}, bus.rs1_data};
      fast_b    = {{W{in_sgn_b & bus.rs2_data[W-1]}}, bus.rs2_data};
      fast_prod = fast_a * fast_b;
   end
`endif

   // Shift-add multiply step and restoring divide step on the shared accumulator.
   always_comb begin
      mul_sum  = {1'b0, acc[DW-1:W]} + (acc[0] ? {1'b0, opnd} : (W+1)'(0));
      mul_step = {mul_sum, acc[W-1:1]};
      div_sh   = {acc[DW-1:W], acc[W-1]};
      div_diff = div_sh - {1'b0, opnd};
      div_step = div_diff[W] ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc[W-2:0], 1'b1};
      step_val = fn[2] ? div_step : mul_step;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and datapath next values.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      acc_nx    = acc;
      opnd_nx   = opnd;
      fn_nx     = fn;
      neg_nx    = neg;
      result_nx = result_q;
      rd_nx     = rd_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               fn_nx   = bus.funct3;
               rd_nx   = bus.rd_in;
               neg_nx  = in_neg_res;
               cnt_nx  = '0;
               acc_nx  = {{W{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
               opnd_nx = in_div ? in_mag_b : in_mag_a;
               if (in_div_zero || in_ovf) begin
                  result_nx = in_special;
                  state_nx  = DONE;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!in_div) begin
                  result_nx = pick_result(bus.funct3, 1'b0, fast_prod);
                  state_nx  = DONE;
               end
`endif
               else begin
                  state_nx = CALC;
               end
            end
         end
         CALC: begin
            acc_nx = step_val;
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
               result_nx = pick_result(fn, neg, step_val);
               state_nx  = DONE;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         fn       <= '0;
         neg      <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         cnt      <= cnt_nx;
         acc      <= acc_nx;
         opnd     <= opnd_nx;
         fn       <= fn_nx;
         neg      <= neg_nx;
         result_q <= result_nx;
         rd_q     <= rd_nx;
         busy_q   <= (state_nx != IDLE);
         done_q   <= (state_nx == DONE);
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.reg_write = done_q;
   assign bus.rd_out    = rd_q;
   assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 32;
`endif

   muldiv_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Issue one operation and wait (bounded) for its done pulse.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output logic wr, output int lat, output logic done_after);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = f;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_in    = rd;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.funct3   = ~f;
      bus.rs1_data = 32'hDEADBEEF;
      bus.rs2_data = 32'h12345678;
      bus.rd_in    = 5'd31;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.result;
      rdo = bus.rd_out;
      wr  = bus.reg_write;
      @(posedge clk);
      #1;
      done_after = bus.done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.funct3 = 3'b000; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.reg_write} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.reg_write});
      end
      checks++;
      if (bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin
         errors++; $display("FAIL reset_data: got result %h rd %0d required 0 0", bus.result, bus.rd_out);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] res; logic [4:0] rdo; logic wr; int lat; logic da;
      run_op(3'b000, 32'd7, 32'd6, 5'd5, res, rdo, wr, lat, da);
      checks++;
      if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency: got %0d required %0d", lat, MUL_LAT); end
      checks++;
      if (res !== 32'd42) begin errors++; $display("FAIL mul_7x6: got %h required %h", res, 32'd42); end
      checks++;
      if (rdo !== 5'd5 || wr !== 1'b1) begin errors++; $display("FAIL mul_rd_wr: got rd %0d wr %b required 5 1", rdo, wr); end
      checks++;
      if (da !== 1'b0 || bus.reg_write !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL mul_pulse_width: got done %b wr %b busy %b required 0 0 0", da, bus.reg_write, bus.busy);
      end
      run_op(3'b000, 32'h80000000, 32'hFFFFFFFF, 5'd1, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'h80000000) begin errors++; $display("FAIL mul_min_x_neg1: got %h required 80000000", res); end
   endtask

   task automatic test_mul_high();
      logic [31:0] res; logic [4:0] rdo; logic wr; int lat; logic da;
      run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'h00000000) begin errors++; $display("FAIL mulh: got %h required 00000000", res); end
      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu: got %h required FFFFFFFE", res); end
      run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd2, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: got %h required FFFFFFFF", res); end
   endtask

   task automatic test_div();
      logic [31:0] res; logic [4:0] rdo; logic wr; int lat; logic da;
      run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd10, res, rdo, wr, lat, da);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL div_latency: got %0d required 32", lat); end
      checks++;
      if (res !== 32'hFFFFFFFD || rdo !== 5'd10) begin errors++; $display("FAIL div_neg7_2: got %h rd %0d required FFFFFFFD 10", res, rdo); end
      run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd11, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg7_2: got %h required FFFFFFFF", res); end
      run_op(3'b101, 32'd100, 32'd7, 5'd12, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h required %h", res, 32'd14); end
      run_op(3'b111, 32'd100, 32'd7, 5'd13, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h required %h", res, 32'd2); end
      run_op(3'b101, 32'hFFFFFFFF, 32'd1, 5'd0, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'hFFFFFFFF || wr !== 1'b1) begin errors++; $display("FAIL divu_max_1_x0: got %h wr %b required FFFFFFFF 1", res, wr); end
   endtask

   task automatic test_special();
      logic [31:0] res; logic [4:0] rdo; logic wr; int lat; logic da;
      run_op(3'b100, 32'd5, 32'd0, 5'd20, res, rdo, wr, lat, da);
      checks++;
      if (lat !== 0 || res !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero: got lat %0d res %h required 0 FFFFFFFF", lat, res); end
      checks++;
      if (da !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL div_by_zero_pulse: got done %b busy %b required 0 0", da, bus.busy); end
      run_op(3'b110, 32'd5, 32'd0, 5'd21, res, rdo, wr, lat, da);
      checks++;
      if (lat !== 0 || res !== 32'd5) begin errors++; $display("FAIL rem_by_zero: got lat %0d res %h required 0 5", lat, res); end
      run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd22, res, rdo, wr, lat, da);
      checks++;
      if (lat !== 0 || res !== 32'h80000000) begin errors++; $display("FAIL div_overflow: got lat %0d res %h required 0 80000000", lat, res); end
      run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd23, res, rdo, wr, lat, da);
      checks++;
      if (lat !== 0 || res !== 32'h0) begin errors++; $display("FAIL rem_overflow: got lat %0d res %h required 0 0", lat, res); end
   endtask

   task automatic test_start_ignored();
      int lat; int extra;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_in = 5'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.rd_in = 5'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b required 1", bus.busy); end
      lat = 6;
      while (bus.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 32 || bus.result !== 32'd14 || bus.rd_out !== 5'd3) begin
         errors++; $display("FAIL ignore_result: got lat %0d res %h rd %0d required 32 0000000e 3", lat, bus.result, bus.rd_out);
      end
      extra = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) extra++; end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL ignore_single_done: got %0d extra pulses required 0", extra); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] res; logic [4:0] rdo; logic wr; int lat; logic da; int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b100; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_in = 5'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.reg_write} !== 3'b000 || bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin
         errors++; $display("FAIL abort_outputs: got busy %b done %b wr %b res %h rd %0d required all 0",
                            bus.busy, bus.done, bus.reg_write, bus.result, bus.rd_out);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) seen++; end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", seen); end
      run_op(3'b000, 32'd3, 32'd3, 5'd4, res, rdo, wr, lat, da);
      checks++;
      if (res !== 32'd9 || rdo !== 5'd4 || lat !== MUL_LAT) begin
         errors++; $display("FAIL abort_then_mul: got res %h rd %0d lat %0d required 00000009 4 %0d", res, rdo, lat, MUL_LAT);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mul_high();
      test_div();
      test_special();
      test_start_ignored();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
